vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator, the next generation of the fixed 640x480 white-screen driver. It generates line/frame counters from the pixel clock and produces sync, data-enable, pixel coordinates and a selectable test pattern on 4-bit-per-channel RGB. The block sits between the pixel clock domain and the board's resistor-DAC VGA pins, and is the base for later pattern and sprite blocks that consume `x`/`y`/`de`.

---
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with selectable test patterns.
// Every output is registered, so the pins show the counter state one cycle late.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic [7:0]  frame
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W   = H_VISIBLE / 8;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);

    // 12-bit thresholds so a sync window ending exactly at 2048 still compares correctly
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] HS_BEGIN = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
    localparam logic [11:0] VS_BEGIN = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hc;
    logic [10:0] vc;
    logic [7:0]  frame_cnt;
    logic [1:0]  mode_q;
    logic [2:0]  bar_idx;
    logic [10:0] bar_px;

    logic        hc_wrap;
    logic        vc_wrap;
    logic        origin;
    logic [1:0]  mode_eff;
    logic        de_n;
    logic        hs_n;
    logic        vs_n;
    logic [3:0]  r_n;
    logic [3:0]  g_n;
    logic [3:0]  b_n;

    assign hc_wrap = (hc == H_LAST);
    assign vc_wrap = (vc == V_LAST);
    assign origin  = (hc == 11'd0) && (vc == 11'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc        <= '0;
            vc        <= '0;
            frame_cnt <= '0;
            mode_q    <= '0;
            bar_idx   <= '0;
            bar_px    <= '0;
        end else begin
            hc <= hc_wrap ? 11'd0 : hc + 11'd1;
            if (hc_wrap) begin
                vc <= vc_wrap ? 11'd0 : vc + 11'd1;
            end
            if (hc_wrap && vc_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (origin) begin
                mode_q <= mode;
            end
            // Bar position tracks hc by counting pixels within each bar instead of dividing
            if (hc_wrap) begin
                bar_idx <= '0;
                bar_px  <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_idx <= bar_idx + 3'd1;
                bar_px  <= '0;
            end else begin
                bar_px  <= bar_px + 11'd1;
            end
        end
    end

    always_comb begin
        // At the origin the new mode is used directly, since mode_q only captures it on this edge
        mode_eff = origin ? mode : mode_q;
        de_n     = ({1'b0, hc} < H_VIS) && ({1'b0, vc} < V_VIS);
        hs_n     = (({1'b0, hc} >= HS_BEGIN) && ({1'b0, hc} < HS_END)) ? HS_POL : ~HS_POL;
        vs_n     = (({1'b0, vc} >= VS_BEGIN) && ({1'b0, vc} < VS_END)) ? VS_POL : ~VS_POL;
        r_n      = 4'h0;
        g_n      = 4'h0;
        b_n      = 4'h0;
        if (de_n) begin
            case (mode_eff)
                2'd0: begin
                    r_n = 4'hF;
                    g_n = 4'hF;
                    b_n = 4'hF;
                end
                2'd1: begin
                    r_n = {4{bar_idx[2]}};
                    g_n = {4{bar_idx[1]}};
                    b_n = {4{bar_idx[0]}};
                end
                2'd2: begin
                    r_n = {4{hc[5] ^ vc[5]}};
                    g_n = {4{hc[5] ^ vc[5]}};
                    b_n = {4{hc[5] ^ vc[5]}};
                end
                default: begin
                    r_n = hc[7:4];
                    g_n = vc[7:4];
                    b_n = frame_cnt[5:2];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            frame       <= '0;
        end else begin
            hs          <= hs_n;
            vs          <= vs_n;
            de          <= de_n;
            r           <= r_n;
            g           <= g_n;
            b           <= b_n;
            x           <= hc;
            y           <= vc;
            frame_start <= origin;
            frame       <= frame_cnt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, small inverted-polarity and narrow-line instances.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0, mode_c = 2'd0;

    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b, hs_c, vs_c, de_c, fs_c;
    logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [7:0]  frame_a, frame_b, frame_c;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .mode(mode_a), .r(r_a), .g(g_a), .b(b_a),
        .hs(hs_a), .vs(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .frame_start(fs_a), .frame(frame_a)
    );

    // 12 cycles per line, 7 lines per frame, both syncs active-high
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .mode(mode_b), .r(r_b), .g(g_b), .b(b_b),
        .hs(hs_b), .vs(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .frame_start(fs_b), .frame(frame_b)
    );

    // 68 cycles per line with default vertical timing, keeps full frames short
    vga_timing_gen #(
        .H_VISIBLE(64), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .mode(mode_c), .r(r_c), .g(g_c), .b(b_c),
        .hs(hs_c), .vs(vs_c), .de(de_c), .x(x_c), .y(y_c),
        .frame_start(fs_c), .frame(frame_c)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pulses reset on one instance with a given mode; returns right after release on a falling edge
    task automatic applyStimulus(input int which, input logic [1:0] m);
        @(negedge clk);
        case (which)
            0: begin rst_a = 1'b1; mode_a = m; end
            1: begin rst_b = 1'b1; mode_b = m; end
            default: begin rst_c = 1'b1; mode_c = m; end
        endcase
        repeat (2) @(negedge clk);
        case (which)
            0: rst_a = 1'b0;
            1: rst_b = 1'b0;
            default: rst_c = 1'b0;
        endcase
    endtask

    initial begin
        fork
            begin : branch_default
                int deCount, hsLow, hsFirst, xErr;
                applyStimulus(0, 2'd0);
                repeat (100) @(negedge clk);
                checkOutput("pre_reset_de", int'(de_a), 1);
                @(posedge clk);
                #2 rst_a = 1'b1;
                #1;
                checkOutput("rst_hs", int'(hs_a), 1);
                checkOutput("rst_vs", int'(vs_a), 1);
                checkOutput("rst_de", int'(de_a), 0);
                checkOutput("rst_rgb", int'({r_a, g_a, b_a}), 0);
                checkOutput("rst_x", int'(x_a), 0);
                checkOutput("rst_y", int'(y_a), 0);
                checkOutput("rst_frame", int'(frame_a), 0);
                checkOutput("rst_fs", int'(fs_a), 0);
                @(negedge clk);
                @(negedge clk);
                rst_a = 1'b0;

                deCount = 0; hsLow = 0; hsFirst = -1; xErr = 0;
                for (int i = 0; i < 800; i++) begin
                    @(negedge clk);
                    if (i == 0) begin
                        checkOutput("first_de", int'(de_a), 1);
                        checkOutput("first_x", int'(x_a), 0);
                        checkOutput("first_y", int'(y_a), 0);
                        checkOutput("first_fs", int'(fs_a), 1);
                        checkOutput("first_white", int'({r_a, g_a, b_a}), 12'hFFF);
                    end
                    if (de_a) deCount++;
                    if (!hs_a) begin
                        hsLow++;
                        if (hsFirst < 0) hsFirst = int'(x_a);
                    end
                    if (int'(x_a) != i) xErr++;
                end
                checkOutput("de_cycles", deCount, 640);
                checkOutput("hs_low_cycles", hsLow, 96);
                checkOutput("hs_first_x", hsFirst, 656);
                checkOutput("x_sequence_errs", xErr, 0);
                @(negedge clk);
                checkOutput("line_wrap_x", int'(x_a), 0);
                checkOutput("line_wrap_y", int'(y_a), 1);
                checkOutput("line_wrap_fs", int'(fs_a), 0);

                applyStimulus(0, 2'd1);
                for (int i = 0; i <= 640; i++) begin
                    @(negedge clk);
                    if (i == 0)   checkOutput("bar_x0", int'({r_a, g_a, b_a}), 12'h000);
                    if (i == 80)  checkOutput("bar_x80", int'({r_a, g_a, b_a}), 12'h00F);
                    if (i == 320) checkOutput("bar_x320", int'({r_a, g_a, b_a}), 12'hF00);
                    if (i == 639) checkOutput("bar_x639", int'({r_a, g_a, b_a}), 12'hFFF);
                    if (i == 640) checkOutput("bar_x640", int'({r_a, g_a, b_a}), 12'h000);
                end
            end

            begin : branch_small
                int hsErr, vsErr, deErr, frErr, fsErr, hc, vc;
                @(negedge clk);
                checkOutput("inv_rst_hs", int'(hs_b), 0);
                checkOutput("inv_rst_vs", int'(vs_b), 0);
                checkOutput("inv_rst_de", int'(de_b), 0);
                rst_b = 1'b0;
                hsErr = 0; vsErr = 0; deErr = 0; frErr = 0; fsErr = 0;
                for (int s = 0; s <= 84 * 256; s++) begin
                    @(negedge clk);
                    hc = s % 12;
                    vc = (s / 12) % 7;
                    if (int'(hs_b) != ((hc >= 9 && hc < 11) ? 1 : 0)) hsErr++;
                    if (int'(vs_b) != ((vc == 5) ? 1 : 0)) vsErr++;
                    if (int'(de_b) != ((hc < 8 && vc < 4) ? 1 : 0)) deErr++;
                    if (int'(frame_b) != (s / 84) % 256) frErr++;
                    if (int'(fs_b) != ((s % 84 == 0) ? 1 : 0)) fsErr++;
                    if (s == 9)  checkOutput("inv_hs_active", int'(hs_b), 1);
                    if (s == 60) checkOutput("inv_vs_active", int'(vs_b), 1);
                    if (s == 84 * 255) checkOutput("frame_255", int'(frame_b), 255);
                    if (s == 84 * 256) begin
                        checkOutput("frame_wrap_0", int'(frame_b), 0);
                        checkOutput("frame_wrap_fs", int'(fs_b), 1);
                    end
                end
                checkOutput("small_hs_errs", hsErr, 0);
                checkOutput("small_vs_errs", vsErr, 0);
                checkOutput("small_de_errs", deErr, 0);
                checkOutput("small_frame_errs", frErr, 0);
                checkOutput("small_fs_spacing_errs", fsErr, 0);
            end

            begin : branch_mid
                int whiteErr, vsErr, deErr, hsErr, vsLow, hc, vc;
                applyStimulus(2, 2'd2);
                for (int s = 0; s <= 32 * 68 + 32; s++) begin
                    @(negedge clk);
                    if (s == 0)           checkOutput("chk_0_0", int'({r_c, g_c, b_c}), 12'h000);
                    if (s == 32)          checkOutput("chk_32_0", int'({r_c, g_c, b_c}), 12'hFFF);
                    if (s == 32 * 68)     checkOutput("chk_0_32", int'({r_c, g_c, b_c}), 12'hFFF);
                    if (s == 32 * 68 + 32) checkOutput("chk_32_32", int'({r_c, g_c, b_c}), 12'h000);
                end

                applyStimulus(2, 2'd3);
                repeat (71 * 68 + 54) @(negedge clk);
                checkOutput("grad_x", int'(x_c), 53);
                checkOutput("grad_y", int'(y_c), 71);
                checkOutput("grad_r", int'(r_c), 3);
                checkOutput("grad_g", int'(g_c), 4);
                checkOutput("grad_b", int'(b_c), 0);

                applyStimulus(2, 2'd0);
                whiteErr = 0; vsErr = 0; deErr = 0; hsErr = 0; vsLow = 0;
                for (int s = 0; s <= 35700 + 63; s++) begin
                    @(negedge clk);
                    hc = s % 68;
                    vc = (s / 68) % 525;
                    if (s < 35700) begin
                        if (hc < 64 && vc < 480 && {r_c, g_c, b_c} != 12'hFFF) whiteErr++;
                        if (int'(de_c) != ((hc < 64 && vc < 480) ? 1 : 0)) deErr++;
                        if (int'(hs_c) != ((hc >= 65 && hc < 67) ? 0 : 1)) hsErr++;
                        if (int'(vs_c) != ((vc >= 490 && vc < 492) ? 0 : 1)) vsErr++;
                        if (!vs_c) vsLow++;
                    end
                    if (s == 6800) mode_c = 2'd1;
                    if (s == 35700) begin
                        checkOutput("next_frame_fs", int'(fs_c), 1);
                        checkOutput("next_frame_count", int'(frame_c), 1);
                        checkOutput("next_frame_y", int'(y_c), 0);
                        checkOutput("defer_bar0", int'({r_c, g_c, b_c}), 12'h000);
                    end
                    if (s == 35708) checkOutput("defer_bar1", int'({r_c, g_c, b_c}), 12'h00F);
                    if (s == 35732) checkOutput("defer_bar4", int'({r_c, g_c, b_c}), 12'hF00);
                    if (s == 35763) checkOutput("defer_bar7", int'({r_c, g_c, b_c}), 12'hFFF);
                end
                checkOutput("defer_stays_white_errs", whiteErr, 0);
                checkOutput("mid_de_errs", deErr, 0);
                checkOutput("mid_hs_errs", hsErr, 0);
                checkOutput("vs_window_errs", vsErr, 0);
                checkOutput("vs_low_cycles", vsLow, 136);
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
